vram_write_ctrl: RTL and testbench
==================================

# vram_write_ctrl

Shares the single VRAM write port of the VGA driver between the CPU store path and a hardware fill engine that clears or fills a contiguous VRAM region. Sits between the CPU bus interface and the `Vga` block's `vram_write_addr` / `vram_write_data` / `vram_write_en` inputs. Arbitration is round-robin, so neither requester starves. Every VRAM write is issued from registers one cycle after it is granted.

## Interface
- `ADDR_W`, 16: VRAM word address width.
- `DATA_W`, 16: VRAM write data width.
- `FILL_BASE`, 16'h0000: first address written by a fill.
- `FILL_LEN`, 8192: number of words per fill; legal range 1..65535.

- `clk`  in  1  system clock, the same clock that drives VRAM port A.
- `reset`  in  1  synchronous, active-high reset.
- `cpu_valid`  in  1  CPU write request.
- `cpu_ready`  out  1  CPU write accepted this cycle when high together with `cpu_valid`.
- `cpu_addr`  in  ADDR_W  CPU write address.
- `cpu_data`  in  DATA_W  CPU write data.
- `fill_start`  in  1  single-cycle pulse that starts a fill.
- `fill_value`  in  DATA_W  fill word, sampled on an accepted `fill_start`.
- `fill_busy`  out  1  high while a fill is in progress.
- `fill_done`  out  1  one-cycle pulse when a fill completes.
- `vram_write_addr`  out  ADDR_W  registered address to `Vga`.
- `vram_write_data`  out  DATA_W  registered data to `Vga`.
- `vram_write_en`  out  1  registered write strobe to `Vga`.

## Operation
- The FSM has two states, IDLE and FILL.
  - IDLE → FILL on `fill_start`. At that edge: latch `fill_value`, clear `cnt`, set `last_grant`=CPU.
  - FILL → IDLE on the clock edge where the fill write with `cnt`==FILL_LEN-1 is granted. `fill_done` pulses in the same cycle that write appears on the VRAM port.
- `fill_start` is ignored while in FILL, including on the cycle of the final fill grant.
- In IDLE:
  - `cpu_ready`=1.
  - Every `cpu_valid` is granted.
- In FILL:
  - `cpu_ready` = (`last_grant`==FILL).
  - The fill requests every cycle.
  - CPU grant = `cpu_valid` && `cpu_ready`.
  - Fill grant = !CPU grant.
  - `last_grant` updates to whichever requester was granted.
  - Result: with `cpu_valid` held high, CPU and fill alternate writes. With `cpu_valid` low, the fill writes every cycle.
- Fill address = FILL_BASE + `cnt`, computed modulo 2^ADDR_W (wraps past 16'hFFFF to 0). `cnt` is 16 bits and increments only on a fill grant.
- At most one VRAM write per cycle. A CPU write and a fill write are never merged.
- CPU address and data pass through unchanged. There is no address range check.
- `cpu_ready` depends only on state and `last_grant`, never on `cpu_valid`.

## Timing
- Reset values:
  - `vram_write_en`=0, `vram_write_addr`=0, `vram_write_data`=0.
  - `fill_busy`=0, `fill_done`=0.
  - `cpu_ready`=1, state=IDLE, `cnt`=0, `last_grant`=CPU.
- Latency from a grant at edge N to the write appearing on the VRAM port: `vram_write_en`=1 with matching address and data during cycle N+1.
- When there is no grant, `vram_write_en`=0 next cycle. Address and data hold their last values.
- `fill_busy` rises the cycle after `fill_start` is accepted and falls in the same cycle `fill_done` is high.
- Uncontended fill duration:
  - FILL_LEN writes on consecutive cycles.
  - The first fill write is on the VRAM port 2 cycles after the `fill_start` edge.
  - `fill_done` coincides with the last fill write.
- Reset during a fill aborts it in the next cycle:
  - No `fill_done` pulse.
  - No further writes.
  - A pending CPU request is not granted.
- `fill_start` and `cpu_valid` asserted together while IDLE: the CPU write is granted in that cycle and the fill begins next cycle.

## Structure
- Shared package `vga_pkg`:
  - state enum `vram_ctrl_state_t` (IDLE, FILL).
  - grant enum `vram_grant_t` (CPU, FILL).
  - constant `VRAM_WORDS` = 8192, the default for FILL_LEN.
- One sub-module, `vram_fill_engine`: owns `cnt`, the latched fill value, address generation and last-word detection. Interface: `start`, `grant`, `addr`, `data`, `last`.
- Arbitration, the FSM and the output registers live in `vram_write_ctrl`.

## Test plan
- **Reset, no requests:** hold `reset` 3 cycles, then idle 10 cycles → `cpu_ready`=1, `vram_write_en`=0, address=0, data=0, `fill_busy`=0.
- **CPU only, IDLE:** `cpu_valid` 3 cycles with addr 0x0010/0x0011/0x0012 and data 0xAAAA/0x5555/0x0001 → the same three writes on consecutive cycles, each one cycle later.
- **Fill only, FILL_LEN=8, FILL_BASE=0xFFFC, `fill_value`=0x00FF:**
  - writes to 0xFFFC, 0xFFFD, 0xFFFE, 0xFFFF, 0x0000, 0x0001, 0x0002, 0x0003, all data 0x00FF, on 8 consecutive cycles;
  - `fill_done` with the 8th write;
  - `fill_busy` high exactly 8 cycles.
- **Contention, FILL_LEN=4, `cpu_valid` held with incrementing addr from 0x0100:** strictly alternating F, C, F, C, F, C, F, then CPU-only. `fill_done` on the 4th fill write. No CPU request is lost.
- **`fill_start` re-pulsed mid-fill:** ignored; the fill still writes exactly FILL_LEN words and `fill_done` pulses once.
- **`reset` asserted during the 3rd fill write:** from the next cycle `vram_write_en`=0, `fill_busy`=0, no `fill_done`. A new fill after release restarts at FILL_BASE.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA VRAM write path.
package vga_pkg;

    typedef enum logic {
        StIdle,
        StFill
    } vram_ctrl_state_t;

    typedef enum logic {
        GrantCpu,
        GrantFill
    } vram_grant_t;

    localparam int unsigned VRAM_WORDS = 8192;

endpackage

// File: rtl/vram_fill_engine.sv
// Fill engine: word counter, latched fill value, address generation and last-word detection.
module vram_fill_engine
    import vga_pkg::*;
#(
    parameter int unsigned       ADDR_W    = 16,
    parameter int unsigned       DATA_W    = 16,
    parameter logic [ADDR_W-1:0] FILL_BASE = '0,
    parameter int unsigned       FILL_LEN  = VRAM_WORDS
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              grant,
    input  logic [DATA_W-1:0] value,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] data,
    output logic              last
);

    logic [15:0]       cnt_q, cnt_d;
    logic [DATA_W-1:0] value_q, value_d;

    always_comb begin
        cnt_d   = cnt_q;
        value_d = value_q;
        if (start) begin
            cnt_d   = '0;
            value_d = value;
        end else if (grant) begin
            cnt_d = cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= '0;
            value_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            value_q <= value_d;
        end
    end

    // Address wraps modulo 2^ADDR_W past the top of VRAM.
    assign addr = FILL_BASE + ADDR_W'(cnt_q);
    assign data = value_q;
    assign last = (cnt_q == 16'(FILL_LEN - 1));

endmodule

// File: rtl/vram_write_ctrl.sv
// Round-robin arbiter sharing the VRAM write port between CPU stores and the fill engine.
module vram_write_ctrl
    import vga_pkg::*;
#(
    parameter int unsigned       ADDR_W    = 16,
    parameter int unsigned       DATA_W    = 16,
    parameter logic [ADDR_W-1:0] FILL_BASE = '0,
    parameter int unsigned       FILL_LEN  = VRAM_WORDS
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_valid,
    output logic              cpu_ready,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_data,
    input  logic              fill_start,
    input  logic [DATA_W-1:0] fill_value,
    output logic              fill_busy,
    output logic              fill_done,
    output logic [ADDR_W-1:0] vram_write_addr,
    output logic [DATA_W-1:0] vram_write_data,
    output logic              vram_write_en
);

    vram_ctrl_state_t state_q, state_d;
    vram_grant_t      last_grant_q, last_grant_d;

    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              done_q, done_d;

    logic              cpu_grant;
    logic              fill_grant;
    logic              fill_accept;
    logic [ADDR_W-1:0] fill_addr;
    logic [DATA_W-1:0] fill_data;
    logic              fill_last;

    vram_fill_engine #(
        .ADDR_W   (ADDR_W),
        .DATA_W   (DATA_W),
        .FILL_BASE(FILL_BASE),
        .FILL_LEN (FILL_LEN)
    ) u_fill (
        .clk  (clk),
        .reset(reset),
        .start(fill_accept),
        .grant(fill_grant),
        .value(fill_value),
        .addr (fill_addr),
        .data (fill_data),
        .last (fill_last)
    );

    // CPU is held off in FILL right after its own write so the fill always gets every other slot.
    assign cpu_ready   = (state_q == StIdle) || (last_grant_q == GrantFill);
    assign cpu_grant   = cpu_valid && cpu_ready;
    assign fill_grant  = (state_q == StFill) && !cpu_grant;
    assign fill_accept = (state_q == StIdle) && fill_start;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        wr_en_d      = cpu_grant || fill_grant;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        done_d       = 1'b0;

        if (cpu_grant) begin
            wr_addr_d = cpu_addr;
            wr_data_d = cpu_data;
        end else if (fill_grant) begin
            wr_addr_d = fill_addr;
            wr_data_d = fill_data;
        end

        unique case (state_q)
            StIdle: begin
                if (fill_start) begin
                    state_d      = StFill;
                    last_grant_d = GrantCpu;
                end
            end
            StFill: begin
                last_grant_d = cpu_grant ? GrantCpu : GrantFill;
                if (fill_grant && fill_last) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            last_grant_q <= GrantCpu;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            done_q       <= done_d;
        end
    end

    assign vram_write_en   = wr_en_q;
    assign vram_write_addr = wr_addr_q;
    assign vram_write_data = wr_data_q;
    assign fill_done       = done_q;
    assign fill_busy       = (state_q == StFill);

endmodule

// File: tb/tb_vram_write_ctrl.sv
// Self-checking bench: directed scenarios plus random traffic against a behavioural model.
module tb_vram_write_ctrl;

    localparam int unsigned AW   = 16;
    localparam int unsigned DW   = 16;
    localparam int unsigned LEN  = 8;
    localparam logic [15:0] BASE = 16'hFFFC;

    logic          clk = 1'b0;
    logic          reset;
    logic          cpu_valid;
    logic          cpu_ready;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_data;
    logic          fill_start;
    logic [DW-1:0] fill_value;
    logic          fill_busy;
    logic          fill_done;
    logic [AW-1:0] vram_write_addr;
    logic [DW-1:0] vram_write_data;
    logic          vram_write_en;

    always #5 clk = ~clk;

    vram_write_ctrl #(
        .ADDR_W   (AW),
        .DATA_W   (DW),
        .FILL_BASE(BASE),
        .FILL_LEN (LEN)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .cpu_valid      (cpu_valid),
        .cpu_ready      (cpu_ready),
        .cpu_addr       (cpu_addr),
        .cpu_data       (cpu_data),
        .fill_start     (fill_start),
        .fill_value     (fill_value),
        .fill_busy      (fill_busy),
        .fill_done      (fill_done),
        .vram_write_addr(vram_write_addr),
        .vram_write_data(vram_write_data),
        .vram_write_en  (vram_write_en)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Behavioural model: a fill in progress, words written so far, and whether the fill
    // wrote most recently (which is what lets the CPU in while filling).
    bit          m_fill = 1'b0;
    int          m_cnt  = 0;
    bit          m_fill_wrote_last = 1'b0;
    logic [15:0] m_val  = '0;
    bit          e_en   = 1'b0;
    bit          e_done = 1'b0;
    logic [15:0] e_addr = '0;
    logic [15:0] e_data = '0;

    logic [15:0] log_addr[$];
    logic [15:0] log_data[$];
    int          log_step[$];
    int          step_no     = 0;
    int          done_count  = 0;
    int          busy_cycles = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (step %0d)", name, act, exp, step_no);
        end
    endtask

    task automatic clear_logs();
        log_addr.delete();
        log_data.delete();
        log_step.delete();
        done_count  = 0;
        busy_cycles = 0;
    endtask

    // One clock: drive at negedge, predict the edge, compare at the next negedge.
    task automatic step(input bit rst, input bit cv, input logic [15:0] ca, input logic [15:0] cd,
                        input bit fs, input logic [15:0] fv, output bit acc);
        bit cpu_ok, cpu_go, fill_go, was_fill;
        reset      = rst;
        cpu_valid  = cv;
        cpu_addr   = ca;
        cpu_data   = cd;
        fill_start = fs;
        fill_value = fv;
        cpu_ok     = !m_fill || m_fill_wrote_last;
        #1;
        if (!rst) check("cpu_ready", cpu_ready, cpu_ok);
        acc = 1'b0;
        if (rst) begin
            m_fill = 1'b0; m_cnt = 0; m_fill_wrote_last = 1'b0;
            e_en = 1'b0; e_done = 1'b0; e_addr = '0; e_data = '0;
        end else begin
            was_fill = m_fill;
            cpu_go   = cv && cpu_ok;
            fill_go  = was_fill && !cpu_go;
            acc      = cpu_go;
            e_done   = 1'b0;
            e_en     = cpu_go || fill_go;
            if (cpu_go) begin
                e_addr = ca;
                e_data = cd;
                m_fill_wrote_last = 1'b0;
            end
            if (fill_go) begin
                e_addr = 16'(int'(BASE) + m_cnt);
                e_data = m_val;
                m_cnt++;
                m_fill_wrote_last = 1'b1;
                if (m_cnt == LEN) begin
                    e_done = 1'b1;
                    m_fill = 1'b0;
                end
            end
            if (!was_fill && fs) begin
                m_fill = 1'b1; m_cnt = 0; m_val = fv; m_fill_wrote_last = 1'b0;
            end
        end
        @(posedge clk);
        @(negedge clk);
        step_no++;
        check("wr_en", vram_write_en, e_en);
        check("wr_addr", vram_write_addr, e_addr);
        check("wr_data", vram_write_data, e_data);
        check("fill_done", fill_done, e_done);
        check("fill_busy", fill_busy, m_fill);
        if (vram_write_en === 1'b1) begin
            log_addr.push_back(vram_write_addr);
            log_data.push_back(vram_write_data);
            log_step.push_back(step_no);
        end
        if (fill_done === 1'b1) done_count++;
        if (fill_busy === 1'b1) busy_cycles++;
    endtask

    task automatic idle(input int n);
        bit acc;
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0, 1'b0, '0, acc);
    endtask

    initial begin : main
        bit          acc;
        int          s0;
        int          fills;
        logic [15:0] a;
        logic [15:0] ra, rd;
        bit          rv;
        logic [15:0] exp_addrs[8];
        logic [15:0] exp_cpu;
        logic [15:0] cpu_a[3];
        logic [15:0] cpu_d[3];

        exp_addrs = '{16'hFFFC, 16'hFFFD, 16'hFFFE, 16'hFFFF,
                      16'h0000, 16'h0001, 16'h0002, 16'h0003};
        cpu_a = '{16'h0010, 16'h0011, 16'h0012};
        cpu_d = '{16'hAAAA, 16'h5555, 16'h0001};
        reset = 1'b1; cpu_valid = 1'b0; cpu_addr = '0; cpu_data = '0;
        fill_start = 1'b0; fill_value = '0;
        @(negedge clk);

        // Reset, no requests.
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, '0, '0, 1'b0, '0, acc);
        idle(10);
        check("rst_ready", cpu_ready, 1'b1);
        check("rst_en", vram_write_en, 1'b0);
        check("rst_addr", vram_write_addr, 16'h0000);
        check("rst_data", vram_write_data, 16'h0000);
        check("rst_busy", fill_busy, 1'b0);

        // CPU only while idle.
        clear_logs();
        for (int i = 0; i < 3; i++) step(1'b0, 1'b1, cpu_a[i], cpu_d[i], 1'b0, '0, acc);
        idle(2);
        check("cpu_count", log_addr.size(), 3);
        for (int i = 0; i < 3 && i < log_addr.size(); i++) begin
            check("cpu_addr_lit", log_addr[i], cpu_a[i]);
            check("cpu_data_lit", log_data[i], cpu_d[i]);
            check("cpu_step_lit", log_step[i], step_no - 4 + i);
        end

        // Fill only, wrapping past the top of the address space.
        clear_logs();
        s0 = step_no;
        step(1'b0, 1'b0, '0, '0, 1'b1, 16'h00FF, acc);
        idle(12);
        check("fill_count", log_addr.size(), 8);
        for (int i = 0; i < 8 && i < log_addr.size(); i++) begin
            check("fill_addr_lit", log_addr[i], exp_addrs[i]);
            check("fill_data_lit", log_data[i], 16'h00FF);
            check("fill_step_lit", log_step[i] - s0, 2 + i);
        end
        check("fill_busy_cycles", busy_cycles, 8);
        check("fill_done_count", done_count, 1);

        // Contention: CPU held valid with incrementing addresses.
        clear_logs();
        step(1'b0, 1'b0, '0, '0, 1'b1, 16'hF111, acc);
        a = 16'h0100;
        for (int i = 0; i < 20; i++) begin
            step(1'b0, 1'b1, a, 16'hC000 | a, 1'b0, '0, acc);
            if (acc) a++;
        end
        idle(2);
        check("cont_count", log_addr.size(), 20);
        exp_cpu = 16'h0100;
        for (int i = 0; i < log_addr.size(); i++) begin
            check("cont_pattern", log_data[i] == 16'hF111, (i < 15) && (i % 2 == 0));
            if (log_data[i] != 16'hF111) begin
                check("cont_cpu_addr", log_addr[i], exp_cpu);
                exp_cpu++;
            end
        end
        check("cont_done", done_count, 1);

        // fill_start re-pulsed mid-fill and on the final grant.
        clear_logs();
        step(1'b0, 1'b0, '0, '0, 1'b1, 16'h0A0A, acc);
        for (int i = 2; i <= 12; i++) step(1'b0, 1'b0, '0, '0, (i == 4) || (i == 9), 16'h1111, acc);
        check("repulse_count", log_addr.size(), 8);
        check("repulse_done", done_count, 1);
        check("repulse_busy", busy_cycles, 8);

        // Reset during the third fill write, then a fresh fill.
        clear_logs();
        step(1'b0, 1'b0, '0, '0, 1'b1, 16'h7777, acc);
        idle(3);
        step(1'b1, 1'b1, 16'h0200, 16'h0200, 1'b0, '0, acc);
        check("abort_en", vram_write_en, 1'b0);
        check("abort_busy", fill_busy, 1'b0);
        idle(4);
        check("abort_count", log_addr.size(), 3);
        check("abort_done", done_count, 0);
        clear_logs();
        step(1'b0, 1'b0, '0, '0, 1'b1, 16'h1234, acc);
        idle(10);
        check("restart_count", log_addr.size(), 8);
        if (log_addr.size() > 0) check("restart_base", log_addr[0], 16'hFFFC);
        check("restart_done", done_count, 1);

        // Random traffic with occasional resets; requests are held until accepted.
        rv = 1'b0; ra = '0; rd = '0; fills = 0;
        for (int i = 0; i < 3000; i++) begin
            if (!rv) begin
                rv = ($urandom_range(0, 2) != 0);
                ra = 16'($urandom);
                rd = 16'($urandom);
            end
            if ($urandom_range(0, 299) == 0) begin
                step(1'b1, rv, ra, rd, 1'b0, '0, acc);
                rv = 1'b0;
            end else begin
                step(1'b0, rv, ra, rd, $urandom_range(0, 19) == 0, 16'($urandom), acc);
                if (acc) rv = 1'b0;
            end
            if (fill_done === 1'b1) fills++;
        end
        idle(20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
